// File: rtl/bist_controller.sv
// ---------------------------------------------------------------------------
// bist_controller
//
// Built-in self-test sequencer. It sits directly upstream of the BIST mode
// multiplexer. A start request makes it do the following:
//   - drive the mux select high,
//   - step an LFSR to produce pseudo-random patterns on To_BIST,
//   - compact the core-logic responses (From_Logic) into a MISR,
//   - compare the final signature against GOLDEN and report pass/fail.
//
// Optional feature: define BIST_ABORT_EN to add the BIST_Abort input. An
// abort in LOAD, RUN or CHECK returns the sequencer to IDLE without
// reporting a result.
//
// Parameters:
//   N        pattern / response width
//   POLY     LFSR and MISR feedback tap mask
//   SEED     LFSR load value (non-zero)
//   PATTERNS number of responses compacted per run (1..2^N-1)
//   GOLDEN   expected final MISR signature
//
// Ports:
//   Clk            sole clock, rising edge
//   Rst            asynchronous, active-high reset
//   BIST_Start     start request, level-sampled in IDLE and DONE
//   BIST_Abort     (BIST_ABORT_EN only) abandon the current run
//   From_Logic     core-logic response to the current pattern
//   To_BIST        current pattern, feeds the mux BIST data input
//   BIST_Mode_Sel  mux select, 1 = BIST path
//   BIST_Busy      run in progress
//   BIST_Done      result valid
//   BIST_Pass      signature matched GOLDEN, valid while BIST_Done=1
//   Signature      current MISR contents
//   state_dbg      current FSM state, for observation only
//
// Handshake: there is no valid/ready pairing here. BIST_Start is a level
// request. It is honoured only in IDLE and DONE, and only at a clock edge.
// While BIST_Done=1, BIST_Pass is a stable result.
// ---------------------------------------------------------------------------
module bist_controller #(
    parameter int unsigned    N        = 6,
    parameter logic [N-1:0]   POLY     = 6'b110000,
    parameter logic [N-1:0]   SEED     = 6'b000001,
    parameter int unsigned    PATTERNS = 63,
    parameter logic [N-1:0]   GOLDEN   = 6'h00
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         BIST_Start,
`ifdef BIST_ABORT_EN
    input  logic         BIST_Abort,
`endif
    input  logic [N-1:0] From_Logic,
    output logic [N-1:0] To_BIST,
    output logic         BIST_Mode_Sel,
    output logic         BIST_Busy,
    output logic         BIST_Done,
    output logic         BIST_Pass,
    output logic [N-1:0] Signature,
    output logic [2:0]   state_dbg
);

    localparam int unsigned CW = $clog2(PATTERNS + 1);
    localparam logic [CW-1:0] LAST = CW'(PATTERNS - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  lfsr_q, lfsr_d;
    logic [N-1:0]  misr_q, misr_d;
    logic [CW-1:0] count_q, count_d;
    logic          mode_q, mode_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          pass_q, pass_d;
    logic          abort;

`ifdef BIST_ABORT_EN
    assign abort = BIST_Abort;
`else
    assign abort = 1'b0;
`endif

    // Shift left and feed the parity of the tapped bits into bit 0. The LFSR
    // and the MISR share this step. The MISR also XORs in the response.
    function automatic logic [N-1:0] shift_fb(input logic [N-1:0] v);
        return {v[N-2:0], ^(v & POLY)};
    endfunction

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= IDLE;
            lfsr_q  <= '0;
            misr_q  <= '0;
            count_q <= '0;
            mode_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            misr_q  <= misr_d;
            count_q <= count_d;
            mode_q  <= mode_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        misr_d  = misr_q;
        count_d = count_q;
        mode_d  = mode_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;

        case (state_q)
            IDLE, DONE: begin
                // A restart from DONE clears the previous result. It loads
                // exactly as a start from IDLE does.
                if (BIST_Start) begin
                    state_d = LOAD;
                    lfsr_d  = SEED;
                    misr_d  = '0;
                    count_d = '0;
                    mode_d  = 1'b1;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                end
            end
            LOAD: begin
                // Settle cycle. The seed pattern is already on To_BIST, so
                // the first response is valid during the first RUN cycle.
                if (abort) begin
                    state_d = IDLE;
                    mode_d  = 1'b0;
                    busy_d  = 1'b0;
                end else begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                    mode_d  = 1'b0;
                    busy_d  = 1'b0;
                end else begin
                    misr_d  = shift_fb(misr_q) ^ From_Logic;
                    lfsr_d  = shift_fb(lfsr_q);
                    count_d = count_q + 1'b1;
                    if (count_q == LAST) begin
                        state_d = CHECK;
                        mode_d  = 1'b0;
                        busy_d  = 1'b0;
                    end
                end
            end
            CHECK: begin
                // Abort wins over reporting a result.
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    pass_d  = (misr_q == GOLDEN);
                end
            end
            default: begin
                state_d = IDLE;
                mode_d  = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b0;
                pass_d  = 1'b0;
            end
        endcase
    end

    assign To_BIST       = lfsr_q;
    assign BIST_Mode_Sel = mode_q;
    assign BIST_Busy     = busy_q;
    assign BIST_Done     = done_q;
    assign BIST_Pass     = pass_q;
    assign Signature     = misr_q;
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_bist_controller.sv
// ---------------------------------------------------------------------------
// tb_bist_controller
//
// This bench drives two instances of bist_controller with identical inputs:
//   - dut_a has GOLDEN set to the loopback signature from the reference model.
//   - dut_b has that value XOR 1.
//
// Every run uses one of two response sources:
//   - loopback, where From_Logic = To_BIST,
//   - random responses.
//
// The reference model works from a precomputed table of the pattern
// sequence. It folds each applied response into the expected signature.
// ---------------------------------------------------------------------------
module tb_bist_controller;

    localparam int unsigned N        = 6;
    localparam logic [5:0]  POLY     = 6'b110000;
    localparam logic [5:0]  SEED     = 6'b000001;
    localparam int unsigned PATTERNS = 63;

    // Signature of a loopback run: each pattern is compacted as its own
    // response.
    function automatic logic [5:0] loop_sig();
        logic [5:0] p;
        logic [5:0] m;
        p = SEED;
        m = '0;
        for (int i = 0; i < PATTERNS; i++) begin
            m = {m[4:0], ^(m & POLY)} ^ p;
            p = {p[4:0], ^(p & POLY)};
        end
        return m;
    endfunction

    localparam logic [5:0] GOLDEN_A = loop_sig();
    localparam logic [5:0] GOLDEN_B = GOLDEN_A ^ 6'h01;

    // clock / reset
    logic clk;
    logic rst;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic       start;
    logic       abort;
    logic       loopback;
    logic [5:0] rnd_resp;
    logic [5:0] from_logic;

    logic [5:0] to_bist_a, sig_a, to_bist_b, sig_b;
    logic       mode_a, busy_a, done_a, pass_a;
    logic       mode_b, busy_b, done_b, pass_b;
    logic [2:0] st_a, st_b;

    assign from_logic = loopback ? to_bist_a : rnd_resp;

    bist_controller #(
        .N(N), .POLY(POLY), .SEED(SEED), .PATTERNS(PATTERNS), .GOLDEN(GOLDEN_A)
    ) dut_a (
        .Clk(clk), .Rst(rst), .BIST_Start(start),
`ifdef BIST_ABORT_EN
        .BIST_Abort(abort),
`endif
        .From_Logic(from_logic), .To_BIST(to_bist_a), .BIST_Mode_Sel(mode_a),
        .BIST_Busy(busy_a), .BIST_Done(done_a), .BIST_Pass(pass_a),
        .Signature(sig_a), .state_dbg(st_a)
    );

    bist_controller #(
        .N(N), .POLY(POLY), .SEED(SEED), .PATTERNS(PATTERNS), .GOLDEN(GOLDEN_B)
    ) dut_b (
        .Clk(clk), .Rst(rst), .BIST_Start(start),
`ifdef BIST_ABORT_EN
        .BIST_Abort(abort),
`endif
        .From_Logic(from_logic), .To_BIST(to_bist_b), .BIST_Mode_Sel(mode_b),
        .BIST_Busy(busy_b), .BIST_Done(done_b), .BIST_Pass(pass_b),
        .Signature(sig_b), .state_dbg(st_b)
    );

    // scoreboard
    int checks;
    int errors;
    logic [5:0] pat_tab [PATTERNS];
    logic [5:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_a"}, {to_bist_a, mode_a, busy_a, done_a, pass_a, sig_a}, 32'd0);
        check({tag, "_b"}, {to_bist_b, mode_b, busy_b, done_b, pass_b, sig_b}, 32'd0);
    endtask

    // One run from the current IDLE or DONE state. Each index n counts the
    // rising edges after the start edge E0.
    //   pulse_n     : raise Start for one cycle at RUN index n (-1 = never)
    //   rst_n       : assert Rst mid-cycle at index n and stop the run
    //   abort_n     : assert Abort at index n and stop the run
    task automatic do_run(input bit lb, input int pulse_n, input int rst_n, input int abort_n);
        logic [5:0] misr;
        logic [5:0] resp;
        int         mode_cycles;
        int         uniq;
        bit         seen [64];
        misr        = '0;
        mode_cycles = 0;
        uniq        = 0;
        for (int i = 0; i < 64; i++) seen[i] = 1'b0;
        exp_q.delete();
        for (int i = 0; i < int'(PATTERNS); i++) exp_q.push_back(pat_tab[i]);
        loopback = lb;

        @(negedge clk);
        start = 1'b1;
        for (int n = 0; n <= 66; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (mode_a) mode_cycles++;

            if (n == 0) begin
                check("load_mode", mode_a, 1'b1);
                check("load_busy", busy_a, 1'b1);
                check("load_pat", to_bist_a, SEED);
                check("load_done", done_a, 1'b0);
            end

            if (n == rst_n) begin
                #1 rst = 1'b1;
                #1 check_all_zero("rst_mid");
                @(negedge clk);
                rst = 1'b0;
                check_all_zero("rst_mid_rel");
                return;
            end

            if (n == abort_n) begin
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                check("abort_mode", mode_a, 1'b0);
                check("abort_busy", busy_a, 1'b0);
                check("abort_done", done_a, 1'b0);
                check("abort_pass", pass_a, 1'b0);
                repeat (3) begin
                    @(negedge clk);
                    check("abort_idle", {mode_a, busy_a, done_a}, 3'b000);
                end
                return;
            end

            if (n == pulse_n) start = 1'b1;
            rnd_resp = 6'($urandom_range(0, 63));

            if (n >= 1 && n <= int'(PATTERNS)) begin
                check("pattern", to_bist_a, exp_q.pop_front());
                if (!seen[to_bist_a]) uniq++;
                seen[to_bist_a] = 1'b1;
                resp = lb ? pat_tab[n-1] : rnd_resp;
                misr = {misr[4:0], ^(misr & POLY)} ^ resp;
            end

            if (n == int'(PATTERNS) + 1) begin
                check("check_mode", mode_a, 1'b0);
                check("check_busy", busy_a, 1'b0);
                check("check_done", done_a, 1'b0);
            end

            if (n >= int'(PATTERNS) + 2) begin
                check("done_a", done_a, 1'b1);
                check("done_b", done_b, 1'b1);
                check("pass_a", pass_a, misr == GOLDEN_A);
                check("pass_b", pass_b, misr == GOLDEN_B);
                check("sig_a", sig_a, misr);
                check("sig_b", sig_b, misr);
            end
        end
        check("mode_cycles", mode_cycles, PATTERNS + 1);
        check("distinct", uniq, PATTERNS);
        check("no_zero_pat", seen[0], 1'b0);
        check("first_pat", pat_tab[0], SEED);
    endtask

    initial begin
        logic [5:0] p;
        checks   = 0;
        errors   = 0;
        start    = 1'b0;
        abort    = 1'b0;
        loopback = 1'b1;
        rnd_resp = '0;
        rst      = 1'b0;

        p = SEED;
        for (int i = 0; i < int'(PATTERNS); i++) begin
            pat_tab[i] = p;
            p = {p[4:0], ^(p & POLY)};
        end

        // asynchronous reset seen before any clock edge
        #3 rst = 1'b1;
        #1 check_all_zero("rst_async");
        @(negedge clk);
        rst = 1'b0;
        repeat (10) begin
            @(negedge clk);
            check_all_zero("idle_hold");
        end

        do_run(1'b1, -1, -1, -1);    // loopback: dut_a passes, dut_b fails
        do_run(1'b0, -1, -1, -1);    // random responses, restart from DONE
        do_run(1'b1, 20, -1, -1);    // Start pulse during RUN is ignored
        do_run(1'b1, -1, -1, -1);    // restart from DONE, same signature
        do_run(1'b1, -1, 30, -1);    // reset mid-run
        do_run(1'b1, -1, -1, -1);    // clean full run afterwards
`ifdef BIST_ABORT_EN
        do_run(1'b1, -1, -1, 10);    // abort during RUN
        do_run(1'b0, -1, -1, -1);
`endif
        do_run(1'b0, -1, -1, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
